// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state type, BCD digit
// limits and the load-time digit clamp.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
  localparam logic [3:0] BCD_SS_TENS_MAX = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Forces an arbitrary {mm, ss} byte pair into a legal MM:SS BCD value.
  function automatic logic [15:0] load_clamp(input logic [7:0] mm, input logic [7:0] ss);
    return {clamp_digit(mm[7:4], BCD_DIGIT_MAX),
            clamp_digit(mm[3:0], BCD_DIGIT_MAX),
            clamp_digit(ss[7:4], BCD_SS_TENS_MAX),
            clamp_digit(ss[3:0], BCD_DIGIT_MAX)};
  endfunction

endpackage

// File: rtl/bcd_mmss_sub.sv
// Combinational MM:SS BCD minus N seconds, floored at 00:00.
// sat is high when the subtraction reaches or passes zero, i.e. the result
// is 00:00.
module bcd_mmss_sub (
  input  logic [15:0] mmss_in,
  input  logic [12:0] sub_sec,
  output logic [15:0] mmss_out,
  output logic        sat
);

  logic [12:0] total;
  logic [12:0] rem;
  logic [6:0]  mm_bin;
  logic [5:0]  ss_bin;

  // Go through binary seconds so the minute/second borrow falls out of the
  // divide instead of a chain of per-digit borrows.
  always_comb begin
    total  = 13'(mmss_in[15:12]) * 13'd600 + 13'(mmss_in[11:8]) * 13'd60
           + 13'(mmss_in[7:4]) * 13'd10 + 13'(mmss_in[3:0]);
    sat    = (sub_sec >= total);
    rem    = sat ? 13'd0 : (total - sub_sec);
    mm_bin = 7'(rem / 13'd60);
    ss_bin = 6'(rem % 13'd60);
    mmss_out = {4'(mm_bin / 7'd10), 4'(mm_bin % 7'd10),
                4'(ss_bin / 6'd10), 4'(ss_bin % 6'd10)};
  end

endmodule

// File: rtl/bomb_countdown.sv
// MM:SS countdown timer with pause, load presets and expiry pulse.
// Optional feature: define BOMB_COUNTDOWN_PENALTY_EN to honour the penalty
// input; otherwise the port exists but is ignored.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | preset loaded, waiting for start
// RUN      | counting ms_tick pulses, decrementing seconds
// PAUSE    | frozen, ms counter held
// EXPIRED  | reached 00:00, only load leaves
module bomb_countdown
  import timer_pkg::*;
#(
  parameter int MS_PER_SEC  = 1000,
  parameter int PENALTY_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  input  logic        load,
  input  logic [7:0]  load_mm,
  input  logic [7:0]  load_ss,
  input  logic        start,
  input  logic        pause,
  input  logic        penalty,
  output logic [15:0] digits,
  output logic        sec_tick,
  output logic        running,
  output logic        expired,
  output logic        boom
);

  localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

  state_t          state, state_nxt;
  logic [MS_W-1:0] ms_cnt, ms_cnt_nxt;
  logic [15:0]     digits_nxt;
  logic            sec_tick_nxt, boom_nxt;
  logic            sec_due, pen_due;
  logic [12:0]     sub_amt;
  logic [15:0]     sub_res;
  logic            sub_sat;

  assign sec_due = (state == ST_RUN) && ms_tick && (ms_cnt == MS_LAST);

`ifdef BOMB_COUNTDOWN_PENALTY_EN
  localparam int PEN_CLAMP = (PENALTY_SEC > 5999) ? 5999 : PENALTY_SEC;
  localparam logic [12:0] PEN_AMT = 13'(PEN_CLAMP);

  // A penalty landing on a second boundary takes the extra second too.
  assign pen_due = penalty && ((state == ST_RUN) || (state == ST_PAUSE));
  assign sub_amt = pen_due ? (PEN_AMT + 13'(sec_due)) : 13'd1;
`else
  localparam int unused_pen_sec = PENALTY_SEC;
  logic unused_penalty;

  assign unused_penalty = penalty;
  assign pen_due        = 1'b0;
  assign sub_amt        = 13'd1;
`endif

  bcd_mmss_sub u_sub (
    .mmss_in  (digits),
    .sub_sec  (sub_amt),
    .mmss_out (sub_res),
    .sat      (sub_sat)
  );

  // Next-state and next-output decode; load > penalty > second > pause > start.
  always_comb begin
    state_nxt    = state;
    ms_cnt_nxt   = ms_cnt;
    digits_nxt   = digits;
    sec_tick_nxt = 1'b0;
    boom_nxt     = 1'b0;
    if (load) begin
      state_nxt  = ST_IDLE;
      digits_nxt = load_clamp(load_mm, load_ss);
      ms_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (digits == 16'h0000) begin
              state_nxt = ST_EXPIRED;
              boom_nxt  = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (ms_tick) ms_cnt_nxt = sec_due ? '0 : ms_cnt + 1'b1;
          if (pen_due || sec_due) begin
            digits_nxt   = sub_res;
            sec_tick_nxt = sec_due;
            if (sub_sat) begin
              state_nxt = ST_EXPIRED;
              boom_nxt  = 1'b1;
            end
          end else if (pause) begin
            state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pen_due) begin
            digits_nxt = sub_res;
            if (sub_sat) begin
              state_nxt = ST_EXPIRED;
              boom_nxt  = 1'b1;
            end
          end else if (start) begin
            if (digits == 16'h0000) begin
              state_nxt = ST_EXPIRED;
              boom_nxt  = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        default: begin
          digits_nxt = 16'h0000;
        end
      endcase
    end
  end

  // State and registered outputs; reset wins over everything including load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ms_cnt   <= '0;
      digits   <= 16'h0000;
      sec_tick <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
      boom     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ms_cnt   <= ms_cnt_nxt;
      digits   <= digits_nxt;
      sec_tick <= sec_tick_nxt;
      running  <= (state_nxt == ST_RUN);
      expired  <= (state_nxt == ST_EXPIRED);
      boom     <= boom_nxt;
    end
  end

endmodule

// File: doc/bomb_countdown.md
BOMB_COUNTDOWN -- requirements
Module: bomb_countdown

Interface
REQ-001 Parameter MS_PER_SEC, default 1000: ms_tick pulses per displayed second.
REQ-002 Parameter PENALTY_SEC, default 10: seconds removed per accepted penalty.
REQ-003 Port clk  input  1  system clock.
REQ-004 Port rst  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
REQ-005 Port ms_tick  input  1  one-cycle 1 ms pulse from the upstream tick generator.
REQ-006 Port load  input  1  one-cycle pulse; loads the preset time and enters IDLE.
REQ-007 Port load_mm  input  8  preset minutes, two BCD digits {tens, ones}.
REQ-008 Port load_ss  input  8  preset seconds, two BCD digits {tens, ones}.
REQ-009 Port start  input  1  one-cycle pulse; IDLE/PAUSE -> RUN.
REQ-010 Port pause  input  1  one-cycle pulse; RUN -> PAUSE.
REQ-011 Port penalty  input  1  one-cycle pulse; wrong-wire time deduction.
REQ-012 Port digits  output  16  current time, BCD {mm_tens, mm_ones, ss_tens, ss_ones}.
REQ-013 Port sec_tick  output  1  one-cycle pulse on each RUN second decrement.
REQ-014 Port running  output  1  high while in RUN.
REQ-015 Port expired  output  1  level; high in EXPIRED.
REQ-016 Port boom  output  1  one-cycle pulse on the cycle EXPIRED is entered.

Function
REQ-017 The block SHALL implement states IDLE, RUN, PAUSE and EXPIRED.
REQ-018 The block SHALL count ms_tick pulses only in RUN, in a ms counter of width clog2(MS_PER_SEC).
REQ-019 On the ms_tick that brings the count to MS_PER_SEC, the block SHALL clear the counter, decrement digits by one second (BCD borrow ss 00 -> 59 with minutes -1), and pulse sec_tick on the next cycle.
REQ-020 A decrement from 00:01 SHALL yield 00:00, go to EXPIRED, and pulse boom on the same registered cycle.
REQ-021 start while digits == 00:00 SHALL go directly to EXPIRED and pulse boom.
REQ-022 load SHALL clamp each load digit >9 to 9 and ss_tens >5 to 5, clear the ms counter, and go to IDLE from any state, EXPIRED included.
REQ-023 Priority in one cycle: load > penalty > second decrement > pause > start.
REQ-024 A penalty in RUN or PAUSE SHALL subtract PENALTY_SEC seconds, saturate at 00:00, and go to EXPIRED with boom if the result is 00:00.
REQ-025 A penalty coinciding with a second decrement SHALL subtract PENALTY_SEC+1 in total, with the same saturation.
REQ-026 The ms counter SHALL hold its value in PAUSE and resume from it on start.
REQ-027 In EXPIRED, all inputs except load SHALL be ignored and digits SHALL hold 00:00.
REQ-028 All outputs SHALL be registered, with one-cycle latency from the causing input.

Reset
REQ-029 With rst low at a clk edge, the block SHALL be in IDLE with digits=16'h0000, ms counter=0, and sec_tick, running, expired and boom all 0.
REQ-030 Reset SHALL override every other input, including mid-RUN and in the same cycle as load.

Configuration
REQ-031 Macro BOMB_COUNTDOWN_PENALTY_EN defined: the penalty input SHALL be honoured per REQ-024/025.
REQ-032 Macro BOMB_COUNTDOWN_PENALTY_EN undefined: the penalty port SHALL remain present but be ignored, and no penalty subtractor logic SHALL be synthesised.

Structure
REQ-033 The shared package timer_pkg SHALL hold the state enum type and BCD constants (digit max 9, seconds-tens max 5).
REQ-034 The block SHALL use one sub-module, bcd_mmss_sub: a combinational subtract of N seconds from MM:SS BCD with a saturation flag.
REQ-035 The sub-module SHALL be used for both the 1 s decrement and the penalty subtraction.

Verification
REQ-036 MS_PER_SEC=4; load 00:03, start, continuous ms_tick -> digits 00:02, 00:01, 00:00 at 4-tick spacing, then boom for one cycle and expired high.
REQ-037 Load 01:00, start, one second elapses -> digits 00:59 and one sec_tick pulse.
REQ-038 Penalty-enabled build; load 00:15, RUN, penalty -> 00:05; second penalty -> 00:00 with boom.
REQ-039 Penalty coinciding with a second decrement at 00:30 -> 00:19.
REQ-040 Load 00:05, start, 2 ticks, pause, 10 ticks, start, 2 ticks -> second decrement at tick 4 of RUN only.
REQ-041 load_mm=8'hA9, load_ss=8'h7C -> digits 16'h9959; rst low during RUN -> all outputs 0 next cycle.
